// File: rtl/reveal_sequencer.sv
// Minesweeper reveal map owner: reveals a requested cell and flood-fills zero regions by repeated grid sweeps.
// Optional REVEAL_WIN_DETECT_EN adds a registered 'win' output evaluated when each request finishes.
module reveal_sequencer #(
    parameter int GRID_SIZE  = 3,
    parameter int STATE_SIZE = 4,
    parameter int IDX_W      = 4
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    clear,
    input  logic                                    start,
    input  logic [IDX_W-1:0]                        start_idx,
    input  logic [GRID_SIZE*GRID_SIZE-1:0]          bomb_grid,
    input  logic [STATE_SIZE*GRID_SIZE*GRID_SIZE-1:0] counts,
    output logic [GRID_SIZE*GRID_SIZE-1:0]          reveal_grid,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    hit_bomb
`ifdef REVEAL_WIN_DETECT_EN
    ,
    output logic                                    win
`endif
);

    localparam int N = GRID_SIZE * GRID_SIZE;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SWEEP,
        FINISH
    } state_t;

    state_t          state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] scan;
    logic             changed;

    logic [IDX_W-1:0]      sel_idx;
    logic [STATE_SIZE-1:0] sel_count;
    logic                  sel_bomb;
    logic                  sel_revealed;
    int unsigned           sel_row;
    int unsigned           sel_col;
    logic [N-1:0]          nbr_mask;
    logic [N-1:0]          new_bits;
    logic [N-1:0]          start_onehot;

    // CHECK inspects the latched request; SWEEP inspects the scan cell.
    assign sel_idx = (state == CHECK) ? idx : scan;

    always_comb begin
        sel_count    = '0;
        sel_bomb     = 1'b0;
        sel_revealed = 1'b0;
        sel_row      = 0;
        sel_col      = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_count    = counts[i*STATE_SIZE +: STATE_SIZE];
                sel_bomb     = bomb_grid[i];
                sel_revealed = reveal_grid[i];
                sel_row      = i / GRID_SIZE;
                sel_col      = i % GRID_SIZE;
            end
        end
    end

    // Row/column distance test keeps the mask from wrapping across row edges.
    always_comb begin
        nbr_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if ((i / GRID_SIZE) + 1 >= sel_row && (i / GRID_SIZE) <= sel_row + 1 &&
                (i % GRID_SIZE) + 1 >= sel_col && (i % GRID_SIZE) <= sel_col + 1 &&
                !((i / GRID_SIZE) == sel_row && (i % GRID_SIZE) == sel_col)) begin
                nbr_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        new_bits = '0;
        if (sel_revealed && !sel_bomb && sel_count == '0) begin
            new_bits = nbr_mask & ~bomb_grid & ~reveal_grid;
        end
    end

    assign start_onehot = N'(1) << start_idx;

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            state       <= IDLE;
            reveal_grid <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hit_bomb    <= 1'b0;
            idx         <= '0;
            scan        <= '0;
            changed     <= 1'b0;
`ifdef REVEAL_WIN_DETECT_EN
            win         <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        hit_bomb <= 1'b0;
                        busy     <= 1'b1;
`ifdef REVEAL_WIN_DETECT_EN
                        win      <= 1'b0;
`endif
                        if (start_idx <= LAST_IDX) begin
                            reveal_grid <= reveal_grid | start_onehot;
                            idx         <= start_idx;
                            state       <= CHECK;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                CHECK: begin
                    if (sel_bomb) begin
                        hit_bomb <= 1'b1;
                        state    <= FINISH;
                    end else if (sel_count == '0) begin
                        scan    <= '0;
                        changed <= 1'b0;
                        state   <= SWEEP;
                    end else begin
                        state <= FINISH;
                    end
                end
                SWEEP: begin
                    reveal_grid <= reveal_grid | new_bits;
                    if (scan == LAST_IDX) begin
                        // Another pass is needed if anything changed, including this cell.
                        if (changed || (|new_bits)) begin
                            scan    <= '0;
                            changed <= 1'b0;
                        end else begin
                            state <= FINISH;
                        end
                    end else begin
                        scan    <= scan + 1'b1;
                        changed <= changed | (|new_bits);
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
`ifdef REVEAL_WIN_DETECT_EN
                    win   <= (&(reveal_grid | bomb_grid)) && !hit_bomb;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reveal_sequencer.sv
// Self-checking bench for reveal_sequencer: vector table with an expectation queue plus abort/reset sequences.
module tb_reveal_sequencer;

    localparam int GRID_SIZE  = 3;
    localparam int STATE_SIZE = 4;
    localparam int IDX_W      = 4;
    localparam int N          = GRID_SIZE * GRID_SIZE;

    logic                      clock = 1'b0;
    logic                      reset = 1'b0;
    logic                      clear = 1'b0;
    logic                      start = 1'b0;
    logic [IDX_W-1:0]          start_idx = '0;
    logic [N-1:0]              bomb_grid = '0;
    logic [STATE_SIZE*N-1:0]   counts = '0;
    logic [N-1:0]              reveal_grid;
    logic                      busy;
    logic                      done;
    logic                      hit_bomb;
`ifdef REVEAL_WIN_DETECT_EN
    logic                      win;
`endif

    int errors = 0;
    int checks = 0;

    reveal_sequencer #(
        .GRID_SIZE (GRID_SIZE),
        .STATE_SIZE(STATE_SIZE),
        .IDX_W     (IDX_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .start      (start),
        .start_idx  (start_idx),
        .bomb_grid  (bomb_grid),
        .counts     (counts),
        .reveal_grid(reveal_grid),
        .busy       (busy),
        .done       (done),
        .hit_bomb   (hit_bomb)
`ifdef REVEAL_WIN_DETECT_EN
        ,
        .win        (win)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic             clr;
        logic [N-1:0]     bombs;
        logic [IDX_W-1:0] idx;
        logic [N-1:0]     exp_reveal;
        logic             exp_hit;
        logic             exp_win;
        int               exp_lat;
    } vec_t;

    vec_t vecs[7];
    vec_t exp_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [STATE_SIZE*N-1:0] make_counts(input logic [N-1:0] b);
        logic [STATE_SIZE*N-1:0] c;
        int n;
        c = '0;
        for (int r = 0; r < GRID_SIZE; r++) begin
            for (int col = 0; col < GRID_SIZE; col++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < GRID_SIZE &&
                            col + dc >= 0 && col + dc < GRID_SIZE && b[(r + dr) * GRID_SIZE + col + dc])
                            n++;
                    end
                end
                c[(r * GRID_SIZE + col) * STATE_SIZE +: STATE_SIZE] = STATE_SIZE'(n);
            end
        end
        return c;
    endfunction

    task automatic set_board(input logic [N-1:0] b);
        bomb_grid = b;
        counts    = make_counts(b);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        vec_t e;
        int   lat;
        if (v.clr) do_clear();
        set_board(v.bombs);
        start_idx = v.idx;
        start     = 1'b1;
        exp_q.push_back(v);
        @(negedge clock);
        start = 1'b0;
        lat   = 0;
        check($sformatf("v%0d busy_after_start", k), 32'(busy), 32'd1);
        while (!done && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        e = exp_q.pop_front();
        check($sformatf("v%0d done_latency", k), 32'(lat), 32'(e.exp_lat));
        check($sformatf("v%0d reveal_grid", k), 32'(reveal_grid), 32'(e.exp_reveal));
        check($sformatf("v%0d hit_bomb", k), 32'(hit_bomb), 32'(e.exp_hit));
        check($sformatf("v%0d busy_at_done", k), 32'(busy), 32'd0);
`ifdef REVEAL_WIN_DETECT_EN
        check($sformatf("v%0d win", k), 32'(win), 32'(e.exp_win));
`endif
        @(negedge clock);
        check($sformatf("v%0d done_one_cycle", k), 32'(done), 32'd0);
    endtask

    task automatic watch_quiet(input string name, input int cycles);
        int pulses;
        int busy_cycles;
        pulses      = 0;
        busy_cycles = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (done) pulses++;
            if (busy) busy_cycles++;
        end
        check({name, " done_pulses"}, 32'(pulses), 32'd0);
        check({name, " busy_cycles"}, 32'(busy_cycles), 32'd0);
    endtask

    initial begin
        //            clr   bombs    idx    reveal   hit   win   lat
        vecs[0] = '{1'b1, 9'h000, 4'd4,  9'h1FF, 1'b0, 1'b1, 20};
        vecs[1] = '{1'b1, 9'h001, 4'd4,  9'h010, 1'b0, 1'b0, 2};
        vecs[2] = '{1'b0, 9'h001, 4'd4,  9'h010, 1'b0, 1'b0, 2};
        vecs[3] = '{1'b1, 9'h001, 4'd0,  9'h001, 1'b1, 1'b0, 2};
        vecs[4] = '{1'b0, 9'h001, 4'd12, 9'h001, 1'b0, 1'b0, 1};
        vecs[5] = '{1'b1, 9'h001, 4'd8,  9'h1FE, 1'b0, 1'b1, 29};
        vecs[6] = '{1'b1, 9'h020, 4'd0,  9'h0DB, 1'b0, 1'b0, 20};

        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("reset reveal_grid", 32'(reveal_grid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset hit_bomb", 32'(hit_bomb), 32'd0);
`ifdef REVEAL_WIN_DETECT_EN
        check("reset win", 32'(win), 32'd0);
`endif
        reset = 1'b1;
        @(negedge clock);

        for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

        // Start while busy is ignored; clear beats a simultaneous start.
        do_clear();
        set_board(9'h000);
        start_idx = 4'd4;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        start_idx = 4'd8;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("abort busy_during_sweep", 32'(busy), 32'd1);
        check("abort no_done_during_sweep", 32'(done), 32'd0);
        clear     = 1'b1;
        start     = 1'b1;
        start_idx = 4'd2;
        @(negedge clock);
        clear = 1'b0;
        start = 1'b0;
        check("abort reveal_grid", 32'(reveal_grid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        watch_quiet("abort", 30);

        // Reset mid-sweep abandons the operation silently.
        set_board(9'h001);
        start_idx = 4'd8;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (12) @(negedge clock);
        check("midreset busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        check("midreset reveal_grid", 32'(reveal_grid), 32'd0);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset hit_bomb", 32'(hit_bomb), 32'd0);
        reset = 1'b1;
        watch_quiet("midreset", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
